pipelined_addsub: RTL and testbench

- Parametrised, pipelined ripple-carry add/subtract unit; successor to the single-cycle 32-bit ripple_carry_adder.
- Operand width is split into STAGES equal slices. One slice is added per pipeline stage, and the carry is registered between stages, so clock frequency scales with slice width, not full width.
- Valid/ready handshake on both sides; sits in datapaths that need a wide adder at full clock rate with backpressure.

---
 rtl/addsub_pkg.sv | 13 +
 rtl/rca_slice.sv | 26 ++
 rtl/pipelined_addsub.sv | 127 ++++++++++++
 tb/tb_pipelined_addsub.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared configuration helpers for the pipelined add/subtract unit.
package addsub_pkg;

    function automatic int unsigned slice_w(input int unsigned width, input int unsigned stages);
        return (stages == 0) ? 0 : width / stages;
    endfunction

    // A legal configuration splits WIDTH into STAGES equal, non-empty slices.
    function automatic logic cfg_ok(input int unsigned width, input int unsigned stages);
        return (stages != 0) && (width != 0) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/rca_slice.sv
// Combinational W-bit ripple-carry adder built from full-adder cells.
module rca_slice #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < W; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign co = c[W];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry add/subtract: one SLICE-wide add per stage, carry and
// not-yet-used operand bits registered between stages, valid/ready on both sides.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned SLICE = slice_w(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $fatal(1, "pipelined_addsub: WIDTH must be a nonzero multiple of STAGES");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // The whole pipe moves together; it only freezes on an unaccepted result.
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;
    assign b_eff    = sub ? ~b : b;
    assign c0       = sub ? 1'b1 : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int unsigned LO  = (k + 1) * SLICE;
        localparam int unsigned REM = WIDTH - LO;

        logic [SLICE-1:0] x, y, s;
        logic             ci, co;
        logic [LO-1:0]    lo_d, lo_q;
        logic             vld_d, vld_q, co_q;

        rca_slice #(.W(SLICE)) u_slice (
            .x  (x),
            .y  (y),
            .ci (ci),
            .s  (s),
            .co (co)
        );

        if (k == 0) begin : g_head
            assign x     = a[SLICE-1:0];
            assign y     = b_eff[SLICE-1:0];
            assign ci    = c0;
            assign vld_d = in_valid;
            assign lo_d  = s;
        end else begin : g_body
            assign x     = g_stg[k-1].g_skew.ra_q[SLICE-1:0];
            assign y     = g_stg[k-1].g_skew.rb_q[SLICE-1:0];
            assign ci    = g_stg[k-1].co_q;
            assign vld_d = g_stg[k-1].vld_q;
            assign lo_d  = {s, g_stg[k-1].lo_q};
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                co_q  <= 1'b0;
                lo_q  <= '0;
            end else if (adv) begin
                vld_q <= vld_d;
                co_q  <= co;
                lo_q  <= lo_d;
            end
        end

        // Upper operand slices ride along until their stage consumes them.
        if (REM > 0) begin : g_skew
            logic [REM-1:0] ra_d, rb_d, ra_q, rb_q;

            if (k == 0) begin : g_src_in
                assign ra_d = a[WIDTH-1:SLICE];
                assign rb_d = b_eff[WIDTH-1:SLICE];
            end else begin : g_src_prev
                assign ra_d = g_stg[k-1].g_skew.ra_q[REM+SLICE-1:SLICE];
                assign rb_d = g_stg[k-1].g_skew.rb_q[REM+SLICE-1:SLICE];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ra_q <= '0;
                    rb_q <= '0;
                end else if (adv) begin
                    ra_q <= ra_d;
                    rb_q <= rb_d;
                end
            end
        end

        // Top slice sees the operand MSBs, so signed overflow is resolved here.
        if (k == STAGES - 1) begin : g_tail
            logic ovf_d, ovf_q;

            assign ovf_d = (x[SLICE-1] == y[SLICE-1]) && (s[SLICE-1] != x[SLICE-1]);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign out_valid = g_stg[STAGES-1].vld_q;
    assign sum       = g_stg[STAGES-1].lo_q;
    assign cout      = g_stg[STAGES-1].co_q;
    assign ovf       = g_stg[STAGES-1].g_tail.ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: three configurations driven in lockstep, each
// checked against an arithmetic reference model through per-unit scoreboards.
module tb_pipelined_addsub;

    typedef struct packed {
        logic        ovf;
        logic        cout;
        logic [63:0] sum;
    } res_t;

    localparam int WS [3] = '{32, 32, 64};
    localparam bit PAT [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready, cin, sub;
    logic [63:0] a, b;

    logic        ir0, ov0, co0, of0;
    logic [31:0] s0;
    logic        ir1, ov1, co1, of1;
    logic [31:0] s1;
    logic        ir2, ov2, co2, of2;
    logic [63:0] s2;

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(32), .STAGES(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
        .a(a[31:0]), .b(b[31:0]), .cin(cin), .sub(sub),
        .out_valid(ov0), .out_ready(out_ready), .sum(s0), .cout(co0), .ovf(of0)
    );

    pipelined_addsub #(.WIDTH(32), .STAGES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
        .a(a[31:0]), .b(b[31:0]), .cin(cin), .sub(sub),
        .out_valid(ov1), .out_ready(out_ready), .sum(s1), .cout(co1), .ovf(of1)
    );

    pipelined_addsub #(.WIDTH(64), .STAGES(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ov2), .out_ready(out_ready), .sum(s2), .cout(co2), .ovf(of2)
    );

    logic        ir [3];
    logic        ov [3];
    logic        co [3];
    logic        of [3];
    logic [63:0] sm [3];

    always_comb begin
        ir[0] = ir0; ov[0] = ov0; co[0] = co0; of[0] = of0; sm[0] = {32'h0, s0};
        ir[1] = ir1; ov[1] = ov1; co[1] = co1; of[1] = of1; sm[1] = {32'h0, s1};
        ir[2] = ir2; ov[2] = ov2; co[2] = co2; of[2] = of2; sm[2] = s2;
    end

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc_n = 0;
    int          s_cyc;
    int          pops [3] = '{0, 0, 0};
    res_t        sbq [3][$];
    logic        s_ir [3];
    logic        s_ov [3];
    logic        s_co [3];
    logic        s_of [3];
    logic [63:0] s_sum [3];

    int          j, stall_left, p0, stale;
    bit          stalled;
    logic [63:0] held;
    logic [63:0] bpa [10];
    logic [63:0] bpb [10];
    logic        ovh [12];

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", tag, got, want, $time);
    endtask

    // Reference: plain unsigned/signed integer arithmetic at the unit's width.
    function automatic res_t ref_model(input logic [63:0] ra, input logic [63:0] rb,
                                       input logic rcin, input logic rsub, input int w);
        res_t               r;
        logic [63:0]        mask;
        logic [65:0]        ua, ub, tot;
        logic signed [66:0] sa, sb, sr, lim;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        ua   = {2'b00, ra & mask};
        ub   = {2'b00, rb & mask};
        sa   = $signed({1'b0, ua});
        sb   = $signed({1'b0, ub});
        if (ra[w-1]) sa = sa - (67'sd1 <<< w);
        if (rb[w-1]) sb = sb - (67'sd1 <<< w);
        lim = 67'sd1 <<< (w - 1);
        if (rsub) begin
            tot    = ua - ub;
            r.cout = (ua >= ub);
            sr     = sa - sb;
        end else begin
            tot    = ua + ub + 66'(rcin);
            r.cout = tot[w];
            sr     = sa + sb + (rcin ? 67'sd1 : 67'sd0);
        end
        r.sum = tot[63:0] & mask;
        r.ovf = (sr >= lim) || (sr < -lim);
        return r;
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0:       return 64'h0;
            1:       return '1;
            2:       return 64'h8000_0000_8000_0000;
            3:       return 64'h7FFF_FFFF_7FFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Sample just after the falling edge, score the coming rising edge, advance.
    task automatic tick();
        res_t e;
        #1;
        s_cyc = cyc_n;
        for (int k = 0; k < 3; k++) begin
            s_ir[k]  = ir[k];
            s_ov[k]  = ov[k];
            s_co[k]  = co[k];
            s_of[k]  = of[k];
            s_sum[k] = sm[k];
            if (rst_n && s_ov[k] && out_ready) begin
                pops[k]++;
                if (sbq[k].size() == 0) begin
                    check($sformatf("sb%0d_unexpected_valid", k), 66'(s_ov[k]), 66'd0);
                end else begin
                    e = sbq[k].pop_front();
                    check($sformatf("sb%0d_result", k), {s_of[k], s_co[k], s_sum[k]}, e);
                end
            end
            if (rst_n && in_valid && s_ir[k])
                sbq[k].push_back(ref_model(a, b, cin, sub, WS[k]));
        end
        cyc_n++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic directed(input string tag, input logic [31:0] da, input logic [31:0] db,
                            input logic dcin, input logic dsub,
                            input logic [31:0] es, input logic ec, input logic eo);
        int t0, lat;
        a = {32'h0, da}; b = {32'h0, db}; cin = dcin; sub = dsub;
        in_valid = 1'b1; out_ready = 1'b1;
        t0 = cyc_n;
        tick();
        in_valid = 1'b0;
        check({tag, "_accept"}, 66'(s_ir[0]), 66'd1);
        lat = -1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (s_ov[0]) begin
                lat = s_cyc - t0;
                break;
            end
        end
        check({tag, "_latency"}, 66'(lat), 66'd4);
        check({tag, "_sum"}, 66'(s_sum[0]), 66'(es));
        check({tag, "_cout_ovf"}, 66'({s_co[0], s_of[0]}), 66'({ec, eo}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #2;
        for (int k = 0; k < 3; k++)
            check($sformatf("reset_state%0d", k), {of[k], co[k], sm[k]} | 66'(ov[k]), 66'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        directed("carry_cross", 32'h0000FFFF, 32'h1, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0);
        directed("pos_ovf",     32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
        directed("wrap",        32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
        directed("sub_borrow",  32'h5,        32'h7, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        directed("sub_ovf",     32'h80000000, 32'h1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);

        // Backpressure: ten beats, output held off for three cycles.
        for (int i = 0; i < 10; i++) begin
            bpa[i] = {$urandom, $urandom};
            bpb[i] = {$urandom, $urandom};
        end
        cin = 1'b0; sub = 1'b0;
        j = 0; stalled = 1'b0; stall_left = 0; p0 = pops[0];
        for (int c = 0; c < 100 && (pops[0] - p0) < 10; c++) begin
            if (!stalled && ov0) begin
                stalled = 1'b1; stall_left = 3; held = sm[0];
            end
            out_ready = (stall_left == 0);
            in_valid  = (j < 10);
            if (j < 10) begin
                a = bpa[j]; b = bpb[j];
            end
            tick();
            if (in_valid && s_ir[0]) j++;
            if (stall_left > 0) begin
                check("bp_in_ready_low", 66'(s_ir[0]), 66'd0);
                check("bp_sum_stable", 66'(s_sum[0]), 66'(held));
                stall_left--;
            end
        end
        check("bp_stall_seen", 66'(stalled), 66'd1);
        check("bp_result_count", 66'(pops[0] - p0), 66'd10);
        check("bp_none_pending", 66'(sbq[0].size()), 66'd0);
        in_valid = 1'b0; out_ready = 1'b1;

        // Bubbles propagate unchanged, four cycles later.
        for (int i = 0; i < 12; i++) begin
            in_valid = (i < 5) ? PAT[i] : 1'b0;
            a = pick(); b = pick();
            tick();
            ovh[i] = s_ov[0];
        end
        in_valid = 1'b0;
        for (int i = 0; i < 12; i++)
            check($sformatf("bubble_%0d", i), 66'(ovh[i]), 66'((i >= 4 && i < 9) ? PAT[i-4] : 1'b0));

        // Randomised traffic with random backpressure.
        for (int c = 0; c < 160; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 3) != 0);
            a = pick(); b = pick();
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (12) tick();
        for (int k = 0; k < 3; k++)
            check($sformatf("drain%0d", k), 66'(sbq[k].size()), 66'd0);

        // Asynchronous reset with beats in flight.
        sub = 1'b0; cin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = pick(); b = pick();
            tick();
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("midrst_valid%0d", k), 66'(ov[k]), 66'd0);
            check($sformatf("midrst_data%0d", k), {of[k], co[k], sm[k]}, 66'd0);
            sbq[k].delete();
        end
        @(negedge clk);
        tick();
        #2 rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            stale += int'(s_ov[0]) + int'(s_ov[1]) + int'(s_ov[2]);
        end
        check("no_stale_after_reset", 66'(stale), 66'd0);
        directed("post_reset", 32'h12345678, 32'h0FEDCBA9, 1'b1, 1'b0, 32'h22222222, 1'b0, 1'b0);
        repeat (10) tick();
        for (int k = 0; k < 3; k++)
            check($sformatf("final_drain%0d", k), 66'(sbq[k].size()), 66'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
